frame_cmd_ctrl: RTL and testbench
=================================

FRAME_CMD_CTRL -- requirements
Module: frame_cmd_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, byte/operand width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, register-file address width.
REQ-003 The block SHALL have port clk  input  1  reference clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port rx_data  input  DATA_WIDTH  synchronized received byte.
REQ-006 The block SHALL have port rx_valid  input  1  one-cycle pulse qualifying rx_data.
REQ-007 The block SHALL have port rf_addr  output  ADDR_WIDTH  register-file address.
REQ-008 The block SHALL have port rf_wr_en  output  1  one-cycle write strobe.
REQ-009 The block SHALL have port rf_rd_en  output  1  one-cycle read strobe.
REQ-010 The block SHALL have port rf_wr_data  output  DATA_WIDTH  write data.
REQ-011 The block SHALL have port rf_rd_data  input  DATA_WIDTH  read data, qualified by rf_rd_valid.
REQ-012 The block SHALL have port rf_rd_valid  input  1  read-data-valid pulse.
REQ-013 The block SHALL have port alu_en  output  1  one-cycle operation start.
REQ-014 The block SHALL have port alu_func  output  4  ALU function code.
REQ-015 The block SHALL have port alu_out  input  2*DATA_WIDTH  ALU result, qualified by alu_valid.
REQ-016 The block SHALL have port alu_valid  input  1  result-valid pulse.
REQ-017 The block SHALL have port gate_en  output  1  ALU clock-gate enable.
REQ-018 The block SHALL have port tx_data  output  DATA_WIDTH  byte to transmitter.
REQ-019 The block SHALL have port tx_valid  output  1  one-cycle transmit request.
REQ-020 The block SHALL have port tx_busy  input  1  transmitter busy.

Function
REQ-021 FSM states SHALL be IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUNC, ALU_WAIT, TX_LO, TX_HI, TX_DONE.
REQ-022 In IDLE, an rx_valid byte SHALL select the next state: 0xAA -> WR_ADDR, 0xBB -> RD_ADDR, 0xCC -> OPA, 0xDD -> FUNC; any other byte SHALL be discarded, staying in IDLE.
REQ-023 WR_ADDR: on rx_valid, latch rx_data[ADDR_WIDTH-1:0] into rf_addr, then go to WR_DATA.
REQ-024 WR_DATA: on rx_valid, drive rf_wr_data=rx_data and pulse rf_wr_en in the next cycle, then go to IDLE.
REQ-025 RD_ADDR: on rx_valid, latch the address and pulse rf_rd_en in the next cycle, then go to RD_WAIT.
REQ-026 RD_WAIT: on rf_rd_valid, latch rf_rd_data as a single TX byte, then go to TX_LO; the HI byte SHALL be skipped.
REQ-027 OPA/OPB: on rx_valid, write the byte to address 0 (OPA) or address 1 (OPB) using the same one-cycle rf_wr_en pulse; OPA -> OPB -> FUNC.
REQ-028 FUNC: on rx_valid, latch alu_func=rx_data[3:0] and pulse alu_en in the next cycle, then go to ALU_WAIT.
REQ-029 gate_en SHALL be 1 exactly while in FUNC or ALU_WAIT, registered, and 0 elsewhere.
REQ-030 ALU_WAIT: on alu_valid, latch alu_out, then go to TX_LO.
REQ-031 TX_LO/TX_HI: when tx_busy=0, drive tx_data (LSB byte first, then MSB byte) and pulse tx_valid for one cycle.
REQ-032 After each tx_valid, the next byte or exit SHALL wait until tx_busy has been seen 1 and then 0; TX_DONE SHALL return to IDLE.
REQ-033 rx_valid arriving in RD_WAIT, ALU_WAIT or any TX state SHALL be ignored, with no state or output change.
REQ-034 rf_wr_en, rf_rd_en, alu_en and tx_valid SHALL be mutually exclusive and never high for two consecutive cycles.
REQ-035 rf_addr, rf_wr_data, alu_func and tx_data SHALL hold their last value between strobes.

Reset
REQ-036 rst=0 SHALL asynchronously force IDLE and zero all outputs and latched data, including during an operation; no strobe SHALL be issued after reset release until a new command is received.

Verification
REQ-037 Send 0xAA, 0x05, 0x3C -> one rf_wr_en pulse with rf_addr=5 and rf_wr_data=0x3C; state returns to IDLE.
REQ-038 Send 0xBB, 0x02, then rf_rd_valid with 0x7E -> rf_rd_en pulse with addr 2; one tx_valid with tx_data=0x7E; no second byte.
REQ-039 Send 0xCC, 0x12, 0x34, 0x00, then alu_valid with 0x0046 -> writes 0x12@0 and 0x34@1; alu_en with alu_func=0; gate_en high only in FUNC/ALU_WAIT; TX 0x46 then 0x00.
REQ-040 Hold tx_busy=1 during TX_LO -> no tx_valid until tx_busy=0; 0x55 received in ALU_WAIT causes no effect.
REQ-041 Send illegal byte 0x11 in IDLE -> no strobes; assert rst mid-OPB -> all outputs 0, state IDLE, the next 0xAA sequence works normally.

Source files
------------

// File: rtl/frame_cmd_ctrl.sv
// Byte-command front end: decodes received bytes into register-file reads/writes
// and ALU operations, then returns the result to the transmitter as one or two bytes.
module frame_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_valid,
  output logic [ADDR_WIDTH-1:0]   rf_addr,
  output logic                    rf_wr_en,
  output logic                    rf_rd_en,
  output logic [DATA_WIDTH-1:0]   rf_wr_data,
  input  logic [DATA_WIDTH-1:0]   rf_rd_data,
  input  logic                    rf_rd_valid,
  output logic                    alu_en,
  output logic [3:0]              alu_func,
  input  logic [2*DATA_WIDTH-1:0] alu_out,
  input  logic                    alu_valid,
  output logic                    gate_en,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_valid,
  input  logic                    tx_busy
);
  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUNC, ALU_WAIT, TX_LO, TX_HI, TX_DONE
  } state_t;

  localparam logic [DATA_WIDTH-1:0] CMD_WR = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_OP = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_FN = DATA_WIDTH'(8'hDD);

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [DATA_WIDTH-1:0]   wr_data_reg, wr_data_next;
  logic [3:0]              func_reg, func_next;
  logic [DATA_WIDTH-1:0]   tx_data_reg, tx_data_next;
  logic [2*DATA_WIDTH-1:0] result_reg, result_next;
  logic                    single_reg, single_next;
  logic                    sent_reg, sent_next;
  logic                    seen_reg, seen_next;
  logic                    wr_en_reg, wr_en_next;
  logic                    rd_en_reg, rd_en_next;
  logic                    alu_en_reg, alu_en_next;
  logic                    tx_valid_reg, tx_valid_next;
  logic                    gate_reg, gate_next;
  logic                    rx_take;

  // A byte landing while a strobe is high is dropped so strobes can never abut.
  assign rx_take = rx_valid && !(wr_en_reg || rd_en_reg || alu_en_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      wr_data_reg  <= '0;
      func_reg     <= '0;
      tx_data_reg  <= '0;
      result_reg   <= '0;
      single_reg   <= 1'b0;
      sent_reg     <= 1'b0;
      seen_reg     <= 1'b0;
      wr_en_reg    <= 1'b0;
      rd_en_reg    <= 1'b0;
      alu_en_reg   <= 1'b0;
      tx_valid_reg <= 1'b0;
      gate_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      wr_data_reg  <= wr_data_next;
      func_reg     <= func_next;
      tx_data_reg  <= tx_data_next;
      result_reg   <= result_next;
      single_reg   <= single_next;
      sent_reg     <= sent_next;
      seen_reg     <= seen_next;
      wr_en_reg    <= wr_en_next;
      rd_en_reg    <= rd_en_next;
      alu_en_reg   <= alu_en_next;
      tx_valid_reg <= tx_valid_next;
      gate_reg     <= gate_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    wr_data_next  = wr_data_reg;
    func_next     = func_reg;
    tx_data_next  = tx_data_reg;
    result_next   = result_reg;
    single_next   = single_reg;
    sent_next     = sent_reg;
    seen_next     = seen_reg;
    wr_en_next    = 1'b0;
    rd_en_next    = 1'b0;
    alu_en_next   = 1'b0;
    tx_valid_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rx_take) begin
          case (rx_data)
            CMD_WR:  state_next = WR_ADDR;
            CMD_RD:  state_next = RD_ADDR;
            CMD_OP:  state_next = OPA;
            CMD_FN:  state_next = FUNC;
            default: state_next = IDLE;
          endcase
        end
      end
      WR_ADDR: begin
        if (rx_take) begin
          addr_next  = rx_data[ADDR_WIDTH-1:0];
          state_next = WR_DATA;
        end
      end
      WR_DATA: begin
        if (rx_take) begin
          wr_data_next = rx_data;
          wr_en_next   = 1'b1;
          state_next   = IDLE;
        end
      end
      RD_ADDR: begin
        if (rx_take) begin
          addr_next  = rx_data[ADDR_WIDTH-1:0];
          rd_en_next = 1'b1;
          state_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (rf_rd_valid) begin
          result_next = {{DATA_WIDTH{1'b0}}, rf_rd_data};
          single_next = 1'b1;
          state_next  = TX_LO;
        end
      end
      OPA, OPB: begin
        if (rx_take) begin
          addr_next    = (state_reg == OPA) ? ADDR_WIDTH'(0) : ADDR_WIDTH'(1);
          wr_data_next = rx_data;
          wr_en_next   = 1'b1;
          state_next   = (state_reg == OPA) ? OPB : FUNC;
        end
      end
      FUNC: begin
        if (rx_take) begin
          func_next   = rx_data[3:0];
          alu_en_next = 1'b1;
          state_next  = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        if (alu_valid) begin
          result_next = alu_out;
          single_next = 1'b0;
          state_next  = TX_LO;
        end
      end
      // Each byte: send when idle, then require busy to rise and fall before moving on.
      TX_LO, TX_HI: begin
        if (!sent_reg) begin
          if (!tx_busy) begin
            tx_data_next  = (state_reg == TX_LO) ? result_reg[DATA_WIDTH-1:0]
                                                 : result_reg[2*DATA_WIDTH-1:DATA_WIDTH];
            tx_valid_next = 1'b1;
            sent_next     = 1'b1;
          end
        end else if (!seen_reg) begin
          seen_next = tx_busy;
        end else if (!tx_busy) begin
          sent_next  = 1'b0;
          seen_next  = 1'b0;
          state_next = (state_reg == TX_HI || single_reg) ? TX_DONE : TX_HI;
        end
      end
      TX_DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    gate_next = (state_next == FUNC) || (state_next == ALU_WAIT);
  end

  assign rf_addr    = addr_reg;
  assign rf_wr_en   = wr_en_reg;
  assign rf_rd_en   = rd_en_reg;
  assign rf_wr_data = wr_data_reg;
  assign alu_en     = alu_en_reg;
  assign alu_func   = func_reg;
  assign gate_en    = gate_reg;
  assign tx_data    = tx_data_reg;
  assign tx_valid   = tx_valid_reg;
endmodule

// File: tb/tb_frame_cmd_ctrl.sv
// Randomized bench for frame_cmd_ctrl: a transaction-level model predicts the
// strobe/byte sequence; a monitor records what the block actually issues.
module tb_frame_cmd_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [3:0]  rf_addr;
  logic        rf_wr_en, rf_rd_en;
  logic [7:0]  rf_wr_data;
  logic [7:0]  rf_rd_data = '0;
  logic        rf_rd_valid = 1'b0;
  logic        alu_en;
  logic [3:0]  alu_func;
  logic [15:0] alu_out = '0;
  logic        alu_valid = 1'b0;
  logic        gate_en;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_busy;
  logic        tx_busy_resp = 1'b0;
  logic        tx_hold = 1'b0;

  assign tx_busy = tx_busy_resp | tx_hold;
  always #5 clk = ~clk;

  frame_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rf_addr(rf_addr), .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_wr_data(rf_wr_data),
    .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid), .alu_en(alu_en), .alu_func(alu_func),
    .alu_out(alu_out), .alu_valid(alu_valid), .gate_en(gate_en), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_busy(tx_busy)
  );

  // kind: 0 register write, 1 register read, 2 ALU start, 3 transmitted byte
  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [15:0] data;
  } ev_t;

  ev_t  obs_q[$];
  ev_t  exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   proto_err = 0;
  int   gate_err = 0;
  int   tx_cnt = 0;
  logic exp_gate = 1'b0;
  logic prev_strobe = 1'b0;
  logic prev_rst = 1'b0;
  logic [7:0] prev_tx = '0, prev_wd = '0;
  logic [3:0] prev_func = '0;
  int   tx_d;

  always @(negedge clk) begin
    if ((32'(rf_wr_en) + 32'(rf_rd_en) + 32'(alu_en) + 32'(tx_valid)) > 1 ||
        ((rf_wr_en | rf_rd_en | alu_en | tx_valid) && prev_strobe) ||
        (rst && prev_rst && ((tx_data !== prev_tx && !tx_valid) ||
                             (alu_func !== prev_func && !alu_en) ||
                             (rf_wr_data !== prev_wd && !rf_wr_en))))
      proto_err <= proto_err + 1;
    if (gate_en !== exp_gate) gate_err <= gate_err + 1;
    if (rf_wr_en) obs_q.push_back({2'd0, 12'd0, rf_addr, 8'd0, rf_wr_data});
    if (rf_rd_en) obs_q.push_back({2'd1, 12'd0, rf_addr, 16'd0});
    if (alu_en)   obs_q.push_back({2'd2, 16'd0, 12'd0, alu_func});
    if (tx_valid) begin
      obs_q.push_back({2'd3, 16'd0, 8'd0, tx_data});
      tx_cnt <= tx_cnt + 1;
    end
    prev_strobe <= rf_wr_en | rf_rd_en | alu_en | tx_valid;
    prev_rst    <= rst;
    prev_tx     <= tx_data;
    prev_wd     <= rf_wr_data;
    prev_func   <= alu_func;
  end

  // Transmitter: busy for a few cycles after every accepted byte.
  always begin
    @(negedge clk);
    if (tx_valid) begin
      tx_d = $urandom_range(1, 4);
      @(posedge clk); #1 tx_busy_resp = 1'b1;
      repeat (tx_d) @(posedge clk);
      #1 tx_busy_resp = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input bit upd, input bit g);
    @(posedge clk); #1 rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1 rx_valid = 1'b0;
    if (upd) exp_gate = g;
    repeat ($urandom_range(1, 3)) @(posedge clk);
  endtask

  task automatic rd_respond(input logic [7:0] d);
    @(posedge clk); #1 rf_rd_data = d; rf_rd_valid = 1'b1;
    @(posedge clk); #1 rf_rd_valid = 1'b0;
  endtask

  task automatic alu_respond(input logic [15:0] r);
    @(posedge clk); #1 alu_out = r; alu_valid = 1'b1;
    @(posedge clk); #1 alu_valid = 1'b0;
    exp_gate = 1'b0;
  endtask

  task automatic wait_tx(input int target);
    for (int i = 0; i < 300 && tx_cnt < target; i++) @(negedge clk);
    repeat (12) @(posedge clk);
  endtask

  // Reference model: each command maps to its expected transactions.
  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({2'd0, 16'(a % 16), 16'(d)});
    send_byte(8'hAA, 0, 0); send_byte(a, 0, 0); send_byte(d, 0, 0);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] d, input bit noise, input logic [7:0] nb);
    exp_q.push_back({2'd1, 16'(a % 16), 16'd0});
    exp_q.push_back({2'd3, 16'd0, 16'(d)});
    send_byte(8'hBB, 0, 0); send_byte(a, 0, 0);
    if (noise) send_byte(nb, 0, 0);
    rd_respond(d);
    wait_tx(tx_cnt + 1);
  endtask

  task automatic do_alu(input bit ops, input logic [7:0] a, input logic [7:0] b, input logic [7:0] f,
                        input logic [15:0] res, input bit noise, input logic [7:0] nb);
    if (ops) begin
      exp_q.push_back({2'd0, 16'd0, 16'(a)});
      exp_q.push_back({2'd0, 16'd1, 16'(b)});
    end
    exp_q.push_back({2'd2, 16'd0, 16'(f % 16)});
    exp_q.push_back({2'd3, 16'd0, 16'(res % 256)});
    exp_q.push_back({2'd3, 16'd0, 16'(res / 256)});
    if (ops) begin
      send_byte(8'hCC, 0, 0); send_byte(a, 0, 0); send_byte(b, 1, 1);
    end else begin
      send_byte(8'hDD, 1, 1);
    end
    send_byte(f, 0, 0);
    if (noise) send_byte(nb, 0, 0);
    alu_respond(res);
    wait_tx(tx_cnt + 2);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({rf_addr, rf_wr_en, rf_rd_en, rf_wr_data, alu_en, alu_func, gate_en, tx_data, tx_valid} !== '0)
      $display("FAIL reset_outputs: got %h, want 0",
               {rf_addr, rf_wr_en, rf_rd_en, rf_wr_data, alu_en, alu_func, gate_en, tx_data, tx_valid});
    else n_pass++;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    n_checks++;
    if (obs_q.size() !== 0) $display("FAIL reset_no_strobe: got %0d events, want 0", obs_q.size());
    else n_pass++;
  endtask

  task automatic test_write();
    int o0 = obs_q.size(); int e0 = proto_err; int g0 = gate_err;
    exp_q.delete();
    do_write(8'h05, 8'h3C);
    repeat (2) @(posedge clk);
    n_checks++;
    if (obs_q.size() - o0 !== exp_q.size()) $display("FAIL write_count: got %0d, want %0d", obs_q.size() - o0, exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && o0 + i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[o0+i] !== exp_q[i]) $display("FAIL write_ev%0d: got %h, want %h", i, obs_q[o0+i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (proto_err - e0 !== 0 || gate_err - g0 !== 0)
      $display("FAIL write_protocol: got strobe/hold err %0d gate err %0d, want 0 0", proto_err - e0, gate_err - g0);
    else n_pass++;
  endtask

  task automatic test_read();
    int o0 = obs_q.size(); int e0 = proto_err; int g0 = gate_err;
    exp_q.delete();
    do_read(8'h02, 8'h7E, 0, 8'h00);
    n_checks++;
    if (obs_q.size() - o0 !== exp_q.size()) $display("FAIL read_count: got %0d, want %0d", obs_q.size() - o0, exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && o0 + i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[o0+i] !== exp_q[i]) $display("FAIL read_ev%0d: got %h, want %h", i, obs_q[o0+i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (proto_err - e0 !== 0 || gate_err - g0 !== 0)
      $display("FAIL read_protocol: got strobe/hold err %0d gate err %0d, want 0 0", proto_err - e0, gate_err - g0);
    else n_pass++;
  endtask

  task automatic test_alu();
    int o0 = obs_q.size(); int e0 = proto_err; int g0 = gate_err;
    exp_q.delete();
    do_alu(1, 8'h12, 8'h34, 8'h00, 16'h0046, 0, 8'h00);
    n_checks++;
    if (obs_q.size() - o0 !== exp_q.size()) $display("FAIL alu_count: got %0d, want %0d", obs_q.size() - o0, exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && o0 + i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[o0+i] !== exp_q[i]) $display("FAIL alu_ev%0d: got %h, want %h", i, obs_q[o0+i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (proto_err - e0 !== 0 || gate_err - g0 !== 0)
      $display("FAIL alu_protocol: got strobe/hold err %0d gate err %0d, want 0 0", proto_err - e0, gate_err - g0);
    else n_pass++;
  endtask

  task automatic test_tx_busy();
    int o0 = obs_q.size(); int e0 = proto_err; int g0 = gate_err;
    exp_q.delete();
    exp_q.push_back({2'd2, 16'd0, 16'd3});
    exp_q.push_back({2'd3, 16'd0, 16'h00EF});
    exp_q.push_back({2'd3, 16'd0, 16'h00BE});
    tx_hold = 1'b1;
    send_byte(8'hDD, 1, 1);
    send_byte(8'h03, 0, 0);
    send_byte(8'h55, 0, 0);
    alu_respond(16'hBEEF);
    repeat (10) @(posedge clk);
    n_checks++;
    if (obs_q.size() - o0 !== 1) $display("FAIL tx_held: got %0d events while busy, want 1", obs_q.size() - o0);
    else n_pass++;
    tx_hold = 1'b0;
    wait_tx(tx_cnt + 2);
    n_checks++;
    if (obs_q.size() - o0 !== exp_q.size()) $display("FAIL busy_count: got %0d, want %0d", obs_q.size() - o0, exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && o0 + i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[o0+i] !== exp_q[i]) $display("FAIL busy_ev%0d: got %h, want %h", i, obs_q[o0+i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (proto_err - e0 !== 0 || gate_err - g0 !== 0)
      $display("FAIL busy_protocol: got strobe/hold err %0d gate err %0d, want 0 0", proto_err - e0, gate_err - g0);
    else n_pass++;
  endtask

  task automatic test_illegal_and_reset();
    int o0 = obs_q.size(); int e0; int g0;
    send_byte(8'h11, 0, 0);
    repeat (5) @(posedge clk);
    n_checks++;
    if (obs_q.size() - o0 !== 0) $display("FAIL illegal_byte: got %0d events, want 0", obs_q.size() - o0);
    else n_pass++;
    send_byte(8'hCC, 0, 0);
    send_byte(8'h12, 0, 0);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({rf_addr, rf_wr_en, rf_rd_en, rf_wr_data, alu_en, alu_func, gate_en, tx_data, tx_valid} !== '0)
      $display("FAIL reset_mid_op: got %h, want 0",
               {rf_addr, rf_wr_en, rf_rd_en, rf_wr_data, alu_en, alu_func, gate_en, tx_data, tx_valid});
    else n_pass++;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    o0 = obs_q.size();
    repeat (6) @(posedge clk);
    n_checks++;
    if (obs_q.size() - o0 !== 0) $display("FAIL post_reset_quiet: got %0d events, want 0", obs_q.size() - o0);
    else n_pass++;
    e0 = proto_err; g0 = gate_err;
    exp_q.delete();
    do_write(8'h0A, 8'h99);
    repeat (2) @(posedge clk);
    n_checks++;
    if (obs_q.size() - o0 !== exp_q.size()) $display("FAIL post_reset_count: got %0d, want %0d", obs_q.size() - o0, exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && o0 + i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[o0+i] !== exp_q[i]) $display("FAIL post_reset_ev%0d: got %h, want %h", i, obs_q[o0+i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (proto_err - e0 !== 0 || gate_err - g0 !== 0)
      $display("FAIL post_reset_protocol: got strobe/hold err %0d gate err %0d, want 0 0", proto_err - e0, gate_err - g0);
    else n_pass++;
  endtask

  task automatic test_random();
    int o0 = obs_q.size(); int e0 = proto_err; int g0 = gate_err;
    logic [7:0] b;
    exp_q.delete();
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: do_write(8'($urandom), 8'($urandom));
        1: do_read(8'($urandom), 8'($urandom), 1'($urandom), 8'($urandom));
        2: do_alu(1, 8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom), 1'($urandom), 8'($urandom));
        3: do_alu(0, 8'h00, 8'h00, 8'($urandom), 16'($urandom), 1'($urandom), 8'($urandom));
        default: begin
          do b = 8'($urandom); while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD);
          send_byte(b, 0, 0);
        end
      endcase
    end
    repeat (4) @(posedge clk);
    n_checks++;
    if (obs_q.size() - o0 !== exp_q.size()) $display("FAIL random_count: got %0d, want %0d", obs_q.size() - o0, exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && o0 + i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[o0+i] !== exp_q[i]) $display("FAIL random_ev%0d: got %h, want %h", i, obs_q[o0+i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (proto_err - e0 !== 0 || gate_err - g0 !== 0)
      $display("FAIL random_protocol: got strobe/hold err %0d gate err %0d, want 0 0", proto_err - e0, gate_err - g0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_alu();
    test_tx_busy();
    test_illegal_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
